// File: rtl/gigatron_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : gigatron_spi_target
// Purpose  : SPI mode-0 responder for the Gigatron bit-banged ctrl-port bus.
// Revision : 1.0
// ============================================================================
module gigatron_spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       active,
    output logic       abort
);

    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int c_EDGE_W = c_STAGES + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // sclk/ss_n carry one extra flop so the edge compare uses two settled stages
    logic [c_EDGE_W-1:0] r_sclk_sync;
    logic [c_EDGE_W-1:0] r_ss_sync;
    logic [c_STAGES-1:0] r_mosi_sync;

    state_t     r_state;
    logic       r_miso;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_empty;
    logic       r_active;
    logic       r_abort;
    logic [2:0] r_bitcnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_tx_hold;

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_ss_fall;
    logic       w_ss_rise;
    logic       w_mosi_s;
    logic       w_accept;
    logic [7:0] w_load_byte;
    logic [7:0] w_rx_next;

    assign w_sclk_rise = r_sclk_sync[c_EDGE_W-2] & ~r_sclk_sync[c_EDGE_W-1];
    assign w_sclk_fall = ~r_sclk_sync[c_EDGE_W-2] & r_sclk_sync[c_EDGE_W-1];
    assign w_ss_fall   = ~r_ss_sync[c_EDGE_W-2] & r_ss_sync[c_EDGE_W-1];
    assign w_ss_rise   = r_ss_sync[c_EDGE_W-2] & ~r_ss_sync[c_EDGE_W-1];
    assign w_mosi_s    = r_mosi_sync[c_STAGES-1];
    assign w_accept    = tx_load & r_tx_empty;
    assign w_load_byte = r_tx_empty ? IDLE_BYTE : r_tx_hold;
    assign w_rx_next   = {r_rx_shift[6:0], w_mosi_s};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sclk_sync <= {c_EDGE_W{1'b0}};
            r_ss_sync   <= {c_EDGE_W{1'b1}};
            r_mosi_sync <= {c_STAGES{1'b1}};
            r_state     <= ST_IDLE;
            r_miso      <= 1'b1;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_empty  <= 1'b1;
            r_active    <= 1'b0;
            r_abort     <= 1'b0;
            r_bitcnt    <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_tx_hold   <= 8'h00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[c_EDGE_W-2:0], sclk};
            r_ss_sync   <= {r_ss_sync[c_EDGE_W-2:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[c_STAGES-2:0], mosi};
            r_rx_valid  <= 1'b0;
            r_abort     <= 1'b0;

            if (w_accept) begin
                r_tx_hold  <= tx_data;
                r_tx_empty <= 1'b0;
            end

            // A reload consumes the old holding state; a same-cycle load refills it
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state    <= ST_FRAME;
                        r_active   <= 1'b1;
                        r_bitcnt   <= 3'd0;
                        r_miso     <= w_load_byte[7];
                        r_tx_shift <= {w_load_byte[6:0], 1'b0};
                        if (!w_accept) begin
                            r_tx_empty <= 1'b1;
                        end
                    end
                end
                ST_FRAME: begin
                    if (w_ss_rise) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_miso   <= 1'b1;
                        r_bitcnt <= 3'd0;
                        r_abort  <= (r_bitcnt != 3'd0);
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_next;
                        r_bitcnt   <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_tx_shift <= w_load_byte;
                            if (!w_accept) begin
                                r_tx_empty <= 1'b1;
                            end
                        end
                    end else if (w_sclk_fall) begin
                        r_miso     <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign miso     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_ready = r_tx_empty;
    assign active   = r_active;
    assign abort    = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_gigatron_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_gigatron_spi_target
// Purpose  : Directed, table-driven bench for gigatron_spi_target.
// Revision : 1.0
// ============================================================================
module tb_gigatron_spi_target;

    localparam int c_PH = 6;

    logic       clock;
    logic       reset;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       active;
    logic       abort;

    int         n_checks;
    int         n_errors;
    int         rx_cnt;
    int         abort_cnt;
    logic [7:0] rx_log [16];

    typedef struct {
        logic [7:0] mosi_byte;
        logic       do_load;
        logic [7:0] tx_byte;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs [4];

    gigatron_spi_target #(
        .SYNC_STAGES (2),
        .IDLE_BYTE   (8'hFF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sclk     (sclk),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .active   (active),
        .abort    (abort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 16] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (abort) begin
            abort_cnt = abort_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clock);
        tx_load = 1'b0;
    endtask

    task automatic start_frame();
        ss_n = 1'b0;
        wait_cycles(c_PH);
    endtask

    task automatic end_frame();
        wait_cycles(c_PH);
        ss_n = 1'b1;
        wait_cycles(c_PH);
    endtask

    // Sends the top n bits of b MSB first; m collects MISO seen before each rise
    task automatic xfer_bits(input logic [7:0] b, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_cycles(c_PH);
            m[7-i] = miso;
            sclk = 1'b1;
            wait_cycles(c_PH);
            sclk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] m2;
        int         base_rx;
        int         base_ab;

        n_checks  = 0;
        n_errors  = 0;
        rx_cnt    = 0;
        abort_cnt = 0;
        reset     = 1'b1;
        sclk      = 1'b0;
        ss_n      = 1'b1;
        mosi      = 1'b1;
        tx_data   = 8'h00;
        tx_load   = 1'b0;

        vecs[0] = '{mosi_byte: 8'hA5, do_load: 1'b0, tx_byte: 8'h00, exp_miso: 8'hFF};
        vecs[1] = '{mosi_byte: 8'h00, do_load: 1'b1, tx_byte: 8'h3C, exp_miso: 8'h3C};
        vecs[2] = '{mosi_byte: 8'hC3, do_load: 1'b1, tx_byte: 8'h81, exp_miso: 8'h81};
        vecs[3] = '{mosi_byte: 8'hFF, do_load: 1'b1, tx_byte: 8'h00, exp_miso: 8'h00};

        wait_cycles(3);
        check("reset_miso", {31'd0, miso}, 32'd1);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_active", {31'd0, active}, 32'd0);
        check("reset_abort", {31'd0, abort}, 32'd0);
        reset = 1'b0;
        wait_cycles(c_PH);

        for (int i = 0; i < 4; i++) begin
            base_rx = rx_cnt;
            base_ab = abort_cnt;
            if (vecs[i].do_load) begin
                load_tx(vecs[i].tx_byte);
                check("vec_tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
            end
            start_frame();
            check("vec_active_in_frame", {31'd0, active}, 32'd1);
            check("vec_tx_ready_after_ss", {31'd0, tx_ready}, 32'd1);
            xfer_bits(vecs[i].mosi_byte, 8, m);
            end_frame();
            check("vec_miso_byte", {24'd0, m}, {24'd0, vecs[i].exp_miso});
            check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[i].mosi_byte});
            check("vec_rx_pulses", rx_cnt - base_rx, 32'd1);
            check("vec_abort_pulses", abort_cnt - base_ab, 32'd0);
            check("vec_active_after", {31'd0, active}, 32'd0);
        end

        // Back-to-back bytes with a reply queued during the first byte
        base_rx = rx_cnt;
        base_ab = abort_cnt;
        load_tx(8'h3C);
        start_frame();
        load_tx(8'h81);
        check("b2b_tx_ready_after_2nd_load", {31'd0, tx_ready}, 32'd0);
        xfer_bits(8'h12, 8, m);
        xfer_bits(8'h34, 8, m2);
        end_frame();
        check("b2b_miso_byte1", {24'd0, m}, 32'h3C);
        check("b2b_miso_byte2", {24'd0, m2}, 32'h81);
        check("b2b_rx_pulses", rx_cnt - base_rx, 32'd2);
        check("b2b_rx_byte1", {24'd0, rx_log[base_rx % 16]}, 32'h12);
        check("b2b_rx_byte2", {24'd0, rx_log[(base_rx + 1) % 16]}, 32'h34);
        check("b2b_abort_pulses", abort_cnt - base_ab, 32'd0);
        check("b2b_tx_ready_end", {31'd0, tx_ready}, 32'd1);

        // Abort after 5 bits, then a clean frame
        base_rx = rx_cnt;
        base_ab = abort_cnt;
        start_frame();
        xfer_bits(8'hF0, 5, m);
        end_frame();
        check("abort_pulses", abort_cnt - base_ab, 32'd1);
        check("abort_no_rx", rx_cnt - base_rx, 32'd0);
        check("abort_active", {31'd0, active}, 32'd0);
        start_frame();
        xfer_bits(8'h5A, 8, m);
        end_frame();
        check("post_abort_rx_data", {24'd0, rx_data}, 32'h5A);
        check("post_abort_rx_pulses", rx_cnt - base_rx, 32'd1);
        check("post_abort_miso", {24'd0, m}, 32'hFF);

        // Second load while not ready must be ignored
        load_tx(8'h11);
        check("hs_tx_ready_low", {31'd0, tx_ready}, 32'd0);
        load_tx(8'h22);
        check("hs_tx_ready_still_low", {31'd0, tx_ready}, 32'd0);
        start_frame();
        xfer_bits(8'h96, 8, m);
        end_frame();
        check("hs_miso_first", {24'd0, m}, 32'h11);
        start_frame();
        xfer_bits(8'h69, 8, m);
        end_frame();
        check("hs_miso_second_idle", {24'd0, m}, 32'hFF);
        check("hs_rx_data", {24'd0, rx_data}, 32'h69);

        // Reset mid-frame after 3 bits with a reply pending
        base_rx = rx_cnt;
        base_ab = abort_cnt;
        start_frame();
        load_tx(8'h77);
        xfer_bits(8'hE0, 3, m);
        reset = 1'b1;
        ss_n  = 1'b1;
        sclk  = 1'b0;
        @(negedge clock);
        check("rst_mid_miso", {31'd0, miso}, 32'd1);
        check("rst_mid_active", {31'd0, active}, 32'd0);
        check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(c_PH);
        check("rst_mid_no_rx", rx_cnt - base_rx, 32'd0);
        check("rst_mid_no_abort", abort_cnt - base_ab, 32'd0);
        check("rst_mid_rx_data_cleared", {24'd0, rx_data}, 32'h00);
        start_frame();
        xfer_bits(8'hC3, 8, m);
        end_frame();
        check("post_rst_rx_data", {24'd0, rx_data}, 32'hC3);
        check("post_rst_rx_pulses", rx_cnt - base_rx, 32'd1);
        check("post_rst_miso", {24'd0, m}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gigatron_spi_target.md
Name: gigatron_spi_target

Overview:
- SPI mode-0 responder: the peripheral end of the bit-banged SPI bus the Gigatron CPU drives through its ctrl port (SCLK on bit 0, /SS0 on bit 2) with MOSI and MISO on expansion pins.
- Samples the CPU-driven lines in the system clock domain and presents received bytes on a byte-wide strobe interface.
- Shifts reply bytes back on MISO, MSB first.
- Used as the device-side model and bridge for SD/expansion peripherals.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on sclk, ss_n and mosi (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out when no reply byte is pending.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from the CPU (ctrl[0]); idles low.
- ss_n  input  1  active-low select from the CPU (ctrl[2]).
- mosi  input  1  serial data from the CPU.
- miso  output  1  serial data to the CPU.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- tx_data  input  8  reply byte.
- tx_load  input  1  load tx_data into the reply holding register.
- tx_ready  output  1  holding register is empty; tx_load is accepted.
- active  output  1  a frame is in progress (ss_n asserted after sync).
- abort  output  1  one-cycle pulse; ss_n deasserted mid-byte.

Behaviour:
- Reset values: miso=1, rx_data=0, rx_valid=0, tx_ready=1, active=0, abort=0. Reset also clears the bit counter, shift registers and pending flag, and presets every sync flop to its idle level (sclk=0, ss_n=1, mosi=1).
- Sync: each input passes through SYNC_STAGES flops. Edges are detected by comparing the last two synced stages. Edge detection takes SYNC_STAGES+1 clocks after the pin changes. sclk must stay stable for at least SYNC_STAGES+2 clocks per phase; faster sclk is unsupported.
- FSM states IDLE and FRAME.
- IDLE -> FRAME on synced ss_n falling:
  - active=1, bitcnt=0.
  - Load value is tx_hold if a reply is pending, else IDLE_BYTE.
  - miso <= load[7]; tx_shift <= load<<1.
  - Pending is cleared, so tx_ready=1 on the next cycle.
- FRAME, synced sclk rising:
  - rx_shift <= {rx_shift[6:0], mosi_sync}; bitcnt++ (3-bit counter, wraps).
  - On the 8th bit (bitcnt==7 before the increment):
    - rx_data <= {rx_shift[6:0], mosi_sync}; rx_valid=1 for exactly one clock.
    - tx_shift reloads with the full next byte (tx_hold or IDLE_BYTE); pending clears.
- FRAME, synced sclk falling: miso <= tx_shift[7]; tx_shift <= tx_shift<<1. This puts bit 7 of the next byte on the line after the 8th bit.
- FRAME -> IDLE on synced ss_n rising:
  - active=0, miso=1, bitcnt=0.
  - If bitcnt != 0: abort pulses for one clock, the partial byte is discarded, and no rx_valid is produced.
  - A pending tx_hold is kept for the next frame.
- Simultaneous ss_n rising and sclk edge in the same clock: the ss_n deassert wins and the sclk edge is ignored.
- tx handshake:
  - tx_load with tx_ready=1: tx_hold <= tx_data; pending set; tx_ready=0 on the next cycle.
  - tx_load with tx_ready=0 is ignored; tx_hold is unchanged.
  - tx_load in the same clock as a byte-boundary reload: the reload uses the old state (the pending value or IDLE_BYTE), and the new byte goes to tx_hold for the next byte.
- sclk edges while in IDLE are ignored.
- rx_valid has no back-pressure. rx_data holds its value until the next complete byte.
- Reset asserted mid-frame returns the block to the reset state on the next clock; no rx_valid or abort is emitted.

Test Plan:
- Frame with no reply loaded: CPU shifts 0xA5 on MOSI in 8 bits. rx_valid pulses once with rx_data=0xA5; MISO carries 0xFF; active=1 throughout; abort=0.
- Reply loaded: tx_load 0x3C while in IDLE (tx_ready drops to 0), then a frame sending 0x00. MISO bits read 0,0,1,1,1,1,0,0 on the rising edges; tx_ready=1 after ss_n falls.
- Back-to-back bytes: 0x3C loaded, then 0x81 loaded during byte 1, two bytes sent 0x12, 0x34. rx_valid pulses with 0x12 then 0x34; MISO carries 0x3C then 0x81.
- Abort: ss_n deasserted after 5 bits. abort pulses once; rx_valid stays 0. The next full frame sending 0x5A yields rx_data=0x5A.
- Handshake edge: tx_load 0x11 then tx_load 0x22 while tx_ready=0. The frame returns 0x11; the second load is ignored.
- Reset mid-frame after 3 bits: miso=1, active=0, tx_ready=1. A subsequent frame sending 0xC3 is received correctly.
